// File: rtl/matmul_4x4_stream_adapter.sv
// matmul_4x4_stream_adapter
// Collects 32 signed operands (A row-major, then B row-major) from an input
// stream into registered 4x4 arrays for an external combinational multiplier.
// After MM_LAT cycles it captures the 4x4 product and streams the 16 results
// out row-major. Load and drain never overlap: LOAD -> WAIT -> DRAIN -> LOAD.
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid && ready. valid never depends on ready. While a result is stalled
// (out_valid && !out_ready), out_valid, out_data and out_last hold stable.
module matmul_4x4_stream_adapter #(
    parameter int w      = 8,
    parameter int MM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [w-1:0]     in_data,
    output logic [w-1:0]     mm_a [0:3][0:3],
    output logic [w-1:0]     mm_b [0:3][0:3],
    input  logic [2*w+1:0]   mm_c [0:3][0:3],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*w+1:0]   out_data,
    output logic             out_last,
    output logic             busy
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Wait count value on which the multiplier result is captured.
    localparam logic [7:0] WAIT_LAST = 8'(MM_LAT - 1);

    logic [1:0]     state_q, state_d;
    logic [4:0]     load_cnt_q, load_cnt_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [w-1:0]   a_q [0:3][0:3];
    logic [w-1:0]   a_d [0:3][0:3];
    logic [w-1:0]   b_q [0:3][0:3];
    logic [w-1:0]   b_d [0:3][0:3];
    logic [2*w+1:0] res_q [0:3][0:3];
    logic [2*w+1:0] res_d [0:3][0:3];
    logic           in_fire;
    logic           out_fire;

    assign mm_a = a_q;
    assign mm_b = b_q;

    // Stream status and result selection, all decoded from registered state
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_DRAIN);
        in_fire   = in_valid && (state_q == ST_LOAD);
        out_fire  = out_ready && (state_q == ST_DRAIN);
        out_data  = (state_q == ST_DRAIN) ? res_q[idx_q[3:2]][idx_q[1:0]] : '0;
        out_last  = (state_q == ST_DRAIN) && (idx_q == 4'd15);
        busy      = !((state_q == ST_LOAD) && (load_cnt_q == 5'd0));
    end

    // Next-state logic: operand deserialisation, latency wait, capture, drain
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    // bit 4 selects A/B, bits [3:2] the row, bits [1:0] the column
                    if (!load_cnt_q[4]) begin
                        a_d[load_cnt_q[3:2]][load_cnt_q[1:0]] = in_data;
                    end else begin
                        b_d[load_cnt_q[3:2]][load_cnt_q[1:0]] = in_data;
                    end
                    // 31 + 1 wraps to 0, ready for the next matrix pair
                    load_cnt_d = load_cnt_q + 5'd1;
                    if (load_cnt_q == 5'd31) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 8'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    res_d   = mm_c;
                    state_d = ST_DRAIN;
                    idx_d   = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers with asynchronous reset to an empty, idle adapter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 5'd0;
            wait_cnt_q <= 8'd0;
            idx_q      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    res_q[i][j] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_matmul_4x4_stream_adapter.sv
// Bench for matmul_4x4_stream_adapter: one instance with MM_LAT=1 and one
// with MM_LAT=3, selected by sel. Each instance is paired with a behavioural
// 4x4 multiplier; expected results come from the operand matrices held here.
module tb_matmul_4x4_stream_adapter;

  localparam int W  = 8;
  localparam int CW = 2 * W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic          sel = 1'b0;
  logic          corrupt = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;

  // instance 1 (MM_LAT=1)
  logic          in_valid1, in_ready1, out_ready1, out_valid1, out_last1, busy1;
  logic [CW-1:0] out_data1;
  logic [W-1:0]  mm_a1 [0:3][0:3];
  logic [W-1:0]  mm_b1 [0:3][0:3];
  logic [CW-1:0] mm_c1 [0:3][0:3];

  // instance 3 (MM_LAT=3)
  logic          in_valid3, in_ready3, out_ready3, out_valid3, out_last3, busy3;
  logic [CW-1:0] out_data3;
  logic [W-1:0]  mm_a3 [0:3][0:3];
  logic [W-1:0]  mm_b3 [0:3][0:3];
  logic [CW-1:0] mm_c3 [0:3][0:3];

  // observed (selected) view
  logic          in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [CW-1:0] out_data_s;
  logic [W-1:0]  mm_a_s [0:3][0:3];
  logic [W-1:0]  mm_b_s [0:3][0:3];

  assign in_valid1  = in_valid && !sel;
  assign in_valid3  = in_valid && sel;
  assign out_ready1 = out_ready && !sel;
  assign out_ready3 = out_ready && sel;

  matmul_4x4_stream_adapter #(.w(W), .MM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .mm_a(mm_a1), .mm_b(mm_b1), .mm_c(mm_c1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1)
  );

  matmul_4x4_stream_adapter #(.w(W), .MM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data), .mm_a(mm_a3), .mm_b(mm_b3), .mm_c(mm_c3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3)
  );

  // behavioural external multipliers; instance 3 can be fed garbage on demand
  always_comb begin
    int acc1;
    int acc3;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc1 = 0;
        acc3 = 0;
        for (int k = 0; k < 4; k++) begin
          acc1 += int'($signed(mm_a1[i][k])) * int'($signed(mm_b1[k][j]));
          acc3 += int'($signed(mm_a3[i][k])) * int'($signed(mm_b3[k][j]));
        end
        mm_c1[i][j] = CW'(acc1);
        mm_c3[i][j] = corrupt ? ~CW'(acc3) : CW'(acc3);
      end
    end
  end

  always_comb begin
    in_ready_s  = sel ? in_ready3  : in_ready1;
    out_valid_s = sel ? out_valid3 : out_valid1;
    out_last_s  = sel ? out_last3  : out_last1;
    busy_s      = sel ? busy3      : busy1;
    out_data_s  = sel ? out_data3  : out_data1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        mm_a_s[i][j] = sel ? mm_a3[i][j] : mm_a1[i][j];
        mm_b_s[i][j] = sel ? mm_b3[i][j] : mm_b1[i][j];
      end
    end
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  int mat_a [16];
  int mat_b [16];
  logic [CW-1:0] exp_q [$];

  // reference: C = A*B with plain integer arithmetic, pushed row-major
  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += mat_a[i*4+k] * mat_b[k*4+j];
        exp_q.push_back(CW'(s));
      end
    end
  endtask

  task automatic set_random_mats();
    for (int k = 0; k < 16; k++) begin
      mat_a[k] = int'($urandom_range(0, 255)) - 128;
      mat_b[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // driver: offers 32 operands; gap_mode 0=none, 1=every third cycle, 2=random.
  // Ends at the falling edge after the accepting edge of element 31.
  task automatic send_mats(input int gap_mode, input bit hold_junk);
    int k;
    int cyc;
    int mism;
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 400) begin
      @(negedge clk);
      case (gap_mode)
        1: in_valid = ((cyc % 3) != 2);
        2: in_valid = ($urandom_range(0, 3) != 0);
        default: in_valid = 1'b1;
      endcase
      in_data = (k < 16) ? W'(mat_a[k]) : W'(mat_b[k-16]);
      if (in_valid && in_ready_s) k++;
      cyc++;
    end
    @(negedge clk);
    in_valid = hold_junk;
    in_data = W'($urandom_range(0, 255));
    total++;
    if (k != 32) begin
      bad++;
      $display("FAIL load_timeout: accepted=%0d required=32", k);
    end
    mism = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mm_a_s[i][j] !== W'(mat_a[i*4+j]) || mm_b_s[i][j] !== W'(mat_b[i*4+j])) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL operands: %0d mm_a/mm_b entries differ from loaded matrices", mism);
    end
  endtask

  // drain: rdy_mode 0=always, 1=pattern 1,0,0,1, 2=random. Checks latency in
  // edges after element 31, ordering, out_last, stall stability, in_ready.
  task automatic drain(input int rdy_mode, input int exp_lat, input int nmax,
                       input bit corrupt_after);
    int lat;
    int cyc;
    int n;
    int p;
    bit have_prev;
    logic [CW-1:0] prev_data;
    logic prev_last;
    logic [CW-1:0] exp;
    lat = 0;
    cyc = 0;
    while (!out_valid_s && cyc < 40) begin
      @(negedge clk);
      lat++;
      cyc++;
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL latency: got=%0d edges required=%0d", lat, exp_lat);
    end
    if (corrupt_after) corrupt = 1'b1;
    n = 0;
    p = 0;
    have_prev = 1'b0;
    while (n < nmax && cyc < 400) begin
      case (rdy_mode)
        1: out_ready = (p % 4 == 0) || (p % 4 == 3);
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
      p++;
      total++;
      if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || busy_s !== 1'b1) begin
        bad++;
        $display("FAIL drain_status: valid=%b in_ready=%b busy=%b required 1/0/1 at n=%0d",
                 out_valid_s, in_ready_s, busy_s, n);
      end
      if (have_prev) begin
        total++;
        if (out_data_s !== prev_data || out_last_s !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: data=%0d last=%b held=%0d/%b", $signed(out_data_s),
                   out_last_s, $signed(prev_data), prev_last);
        end
      end
      if (out_ready) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        total++;
        if (out_data_s !== exp) begin
          bad++;
          $display("FAIL out_data[%0d]: got=%0d required=%0d", n, $signed(out_data_s), $signed(exp));
        end
        total++;
        if (out_last_s !== (n == 15)) begin
          bad++;
          $display("FAIL out_last[%0d]: got=%b required=%b", n, out_last_s, (n == 15));
        end
        n++;
        have_prev = 1'b0;
      end else begin
        prev_data = out_data_s;
        prev_last = out_last_s;
        have_prev = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (n != nmax) begin
      bad++;
      $display("FAIL drain_timeout: transfers=%0d required=%0d", n, nmax);
    end
    if (nmax == 16) begin
      total++;
      if (out_valid_s !== 1'b0 || out_last_s !== 1'b0 || in_ready_s !== 1'b1 || busy_s !== 1'b0) begin
        bad++;
        $display("FAIL drain_end: valid=%b last=%b in_ready=%b busy=%b required 0/0/1/0",
                 out_valid_s, out_last_s, in_ready_s, busy_s);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mm_a_s[i][j] !== '0 || mm_b_s[i][j] !== '0) nz++;
    total++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || out_data_s !== '0 ||
        out_last_s !== 1'b0 || busy_s !== 1'b0 || nz != 0) begin
      bad++;
      $display("FAIL %s: valid=%b in_ready=%b data=%0d last=%b busy=%b nonzero_ops=%0d required 0/1/0/0/0/0",
               name, out_valid_s, in_ready_s, out_data_s, out_last_s, busy_s, nz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_identity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i*4+j] = (i == j) ? 1 : 0;
        mat_b[i*4+j] = 4 * i + j - 8;
      end
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 1, 16, 1'b0);
  endtask

  task automatic test_full_scale();
    for (int k = 0; k < 16; k++) begin
      mat_a[k] = -128;
      mat_b[k] = -128;
    end
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 1, 16, 1'b0);
    for (int k = 0; k < 16; k++) mat_b[k] = 127;
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 1, 16, 1'b0);
  endtask

  task automatic test_backpressure();
    set_random_mats();
    push_expected();
    send_mats(0, 1'b0);
    drain(1, 1, 16, 1'b0);
  endtask

  task automatic test_input_gaps();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i*4+j] = (i == j) ? 1 : 0;
        mat_b[i*4+j] = 4 * i + j - 8;
      end
    push_expected();
    send_mats(1, 1'b1);
    drain(0, 1, 16, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    set_random_mats();
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 1, 5, 1'b0);
    rst = 1'b1;
    #1;
    check_idle("reset_mid_drain");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_random_mats();
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 1, 16, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_random_mats();
      push_expected();
      send_mats(2, 1'b0);
      drain(2, 1, 16, 1'b0);
    end
  endtask

  task automatic test_back_to_back_lat3();
    sel = 1'b1;
    set_random_mats();
    push_expected();
    send_mats(0, 1'b0);
    drain(2, 3, 16, 1'b1);
    corrupt = 1'b0;
    set_random_mats();
    push_expected();
    send_mats(0, 1'b0);
    drain(0, 3, 16, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_full_scale();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_drain();
    test_random();
    test_back_to_back_lat3();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected results never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
